// File: rtl/mem_access_ctrl.sv
// MEM-stage controller for a word-wide, negedge-clocked data RAM with no byte lanes.
// Byte and half stores run as read-modify-write; loads are lane-extracted and extended.
module mem_access_ctrl #(
   parameter int ADDR_WIDTH = 12
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_we,
   input  logic [1:0]            req_size,
   input  logic                  req_unsigned,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [31:0]           req_wdata,
   output logic                  rsp_valid,
   output logic                  rsp_err,
   output logic [31:0]           rsp_rdata,
   output logic [ADDR_WIDTH-3:0] ram_addr,
   output logic [31:0]           ram_din,
   output logic                  ram_we,
   output logic                  ram_en,
   input  logic [31:0]           ram_dout
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_READ,
      S_WRITE,
      S_RMW_READ,
      S_RMW_WRITE
   } state_t;

   state_t                r_state;
   state_t                w_next;
   logic [ADDR_WIDTH-1:0] r_addr;
   logic [1:0]            r_size;
   logic                  r_uns;
   logic [31:0]           r_wdata;
   logic [31:0]           r_merged;
   logic                  r_rsp_valid;
   logic                  r_rsp_err;
   logic [31:0]           r_rsp_rdata;
   logic                  w_accept;
   logic                  w_bad;

   function automatic logic [31:0] f_extend(input logic [31:0] word, input logic [1:0] off,
                                            input logic [1:0] size, input logic uns);
      logic [7:0]  b;
      logic [15:0] h;
      logic [31:0] res;
      b = word[{off, 3'b000} +: 8];
      h = word[{off[1], 4'b0000} +: 16];
      case (size)
         2'b00:   res = uns ? {24'b0, b} : {{24{b[7]}}, b};
         2'b01:   res = uns ? {16'b0, h} : {{16{h[15]}}, h};
         default: res = word;
      endcase
      return res;
   endfunction

   function automatic logic [31:0] f_merge(input logic [31:0] word, input logic [31:0] wdata,
                                           input logic [1:0] off, input logic [1:0] size);
      logic [31:0] res;
      res = word;
      if (size == 2'b00) res[{off, 3'b000} +: 8] = wdata[7:0];
      else               res[{off[1], 4'b0000} +: 16] = wdata[15:0];
      return res;
   endfunction

   assign w_accept = req_valid && (r_state == S_IDLE);
   assign w_bad    = (req_size == 2'b11) ||
                     ((req_size == 2'b01) && req_addr[0]) ||
                     ((req_size == 2'b10) && (req_addr[1:0] != 2'b00));

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE: begin
            if (w_accept && !w_bad) begin
               if (!req_we)                w_next = S_READ;
               else if (req_size == 2'b10) w_next = S_WRITE;
               else                        w_next = S_RMW_READ;
            end
         end
         S_RMW_READ: w_next = S_RMW_WRITE;
         default:    w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= S_IDLE;
         r_addr      <= '0;
         r_size      <= 2'b00;
         r_uns       <= 1'b0;
         r_wdata     <= '0;
         r_merged    <= '0;
         r_rsp_valid <= 1'b0;
         r_rsp_err   <= 1'b0;
         r_rsp_rdata <= '0;
      end else begin
         r_state     <= w_next;
         r_rsp_valid <= 1'b0;
         r_rsp_err   <= 1'b0;
         if (w_accept) begin
            r_addr  <= req_addr;
            r_size  <= req_size;
            r_uns   <= req_unsigned;
            r_wdata <= req_wdata;
         end
         // ram_dout holds the word read on the preceding falling edge
         case (r_state)
            S_IDLE: begin
               if (w_accept && w_bad) begin
                  r_rsp_valid <= 1'b1;
                  r_rsp_err   <= 1'b1;
                  r_rsp_rdata <= '0;
               end
            end
            S_READ: begin
               r_rsp_valid <= 1'b1;
               r_rsp_rdata <= f_extend(ram_dout, r_addr[1:0], r_size, r_uns);
            end
            S_RMW_READ: r_merged <= f_merge(ram_dout, r_wdata, r_addr[1:0], r_size);
            default: begin
               r_rsp_valid <= 1'b1;
               r_rsp_rdata <= '0;
            end
         endcase
      end
   end

   assign req_ready = (r_state == S_IDLE);
   assign rsp_valid = r_rsp_valid;
   assign rsp_err   = r_rsp_err;
   assign rsp_rdata = r_rsp_rdata;
   assign ram_addr  = r_addr[ADDR_WIDTH-1:2];
   assign ram_en    = (r_state == S_READ) || (r_state == S_RMW_READ);
   assign ram_we    = (r_state == S_WRITE) || (r_state == S_RMW_WRITE);
   assign ram_din   = (r_state == S_WRITE)     ? r_wdata  :
                      (r_state == S_RMW_WRITE) ? r_merged : 32'h0;

endmodule
